// File: rtl/hz_scoreboard_if.sv
// Decode-stage hazard interface: fetch-side instruction in, decode-side instruction out.
// The master drives instructions and the slave (hazard unit) returns stall, issue and counter.
interface hz_scoreboard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_i;
  logic             instr_valid_i;
  logic             stall_o;
  logic [31:0]      instr_o;
  logic             is_branch_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output instr_i, instr_valid_i,
    input  stall_o, instr_o, is_branch_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, instr_valid_i,
    output stall_o, instr_o, is_branch_o, stall_cnt_o
  );
endinterface

// File: rtl/hz_scoreboard.sv
// Decode hazard unit: shift-register scoreboard of recent rd writes, branch bubbles, stall counter.
// Stall/issue decisions are combinational on instr_i; define HZ_FORWARDING_EN to stall only on load-use.
module hz_scoreboard #(
  parameter int WB_DEPTH   = 2,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  hz_scoreboard_if.slave bus
);

  if (WB_DEPTH < 1 || WB_DEPTH > 4) begin : g_bad_wb_depth
    $error("hz_scoreboard: WB_DEPTH must be in 1..4");
  end
  if (BR_PENALTY < 0 || BR_PENALTY > 3) begin : g_bad_br_penalty
    $error("hz_scoreboard: BR_PENALTY must be in 0..3");
  end

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } hist_t;

  hist_t            hist_q [WB_DEPTH];
  hist_t            hist_d [WB_DEPTH];
  logic [1:0]       br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       use_rs1, use_rs2, wr_rd, is_ctrl, is_load;
  logic       hazard, stall, issue;

  assign opcode = bus.instr_i[6:0];
  assign rd     = bus.instr_i[11:7];
  assign rs1    = bus.instr_i[19:15];
  assign rs2    = bus.instr_i[24:20];

  always_comb begin
    use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL) && (rs1 != 5'd0);
    use_rs2 = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH) && (rs2 != 5'd0);
    wr_rd   = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != 5'd0);
    is_ctrl = (opcode == OP_BRANCH || opcode == OP_JAL || opcode == OP_JALR);
    is_load = (opcode == OP_LOAD);
  end

  // Recorded rd is never x0, so a valid entry can be compared directly against rs.
  always_comb begin
    hazard = 1'b0;
`ifdef HZ_FORWARDING_EN
    if (hist_q[0].vld && hist_q[0].ld &&
        ((use_rs1 && rs1 == hist_q[0].rd) || (use_rs2 && rs2 == hist_q[0].rd))) begin
      hazard = 1'b1;
    end
`else
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (hist_q[k].vld &&
          ((use_rs1 && rs1 == hist_q[k].rd) || (use_rs2 && rs2 == hist_q[k].rd))) begin
        hazard = 1'b1;
      end
    end
`endif
    hazard = hazard && bus.instr_valid_i;
  end

  // Branch bubbles win over the data-hazard check.
  always_comb begin
    stall = 1'b0;
    issue = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (br_cnt_q != 2'd0) begin
      stall = 1'b1;
    end else if (hazard) begin
      stall = 1'b1;
    end else if (bus.instr_valid_i) begin
      issue = 1'b1;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.instr_o     = issue ? bus.instr_i : NOP;
  assign bus.is_branch_o = issue && is_ctrl;
  assign bus.stall_cnt_o = stall_cnt_q;

  always_comb begin
    hist_d[0].vld = issue && wr_rd;
    hist_d[0].rd  = rd;
    hist_d[0].ld  = is_load;
    for (int k = 1; k < WB_DEPTH; k++) begin
      hist_d[k] = hist_q[k-1];
    end

    if (issue && is_ctrl) begin
      br_cnt_d = 2'(BR_PENALTY);
    end else if (br_cnt_q != 2'd0) begin
      br_cnt_d = br_cnt_q - 2'd1;
    end else begin
      br_cnt_d = 2'd0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WB_DEPTH; k++) begin
        hist_q[k] <= '0;
      end
      br_cnt_q    <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < WB_DEPTH; k++) begin
        hist_q[k] <= hist_d[k];
      end
      br_cnt_q    <= br_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
